// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a single-port fixed-latency data memory
// One access in flight at a time; MEM stage has priority, bounded by a fetch starvation guard.

module mem_port_arbiter #(
    parameter int MEM_LATENCY    = 2,
    parameter int MAX_DATA_BURST = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {GRANT_NONE, GRANT_FETCH, GRANT_MEM} grant_t;

    localparam logic [3:0] LAT_LOAD  = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    state_t     state;
    grant_t     grant;
    logic [3:0] streak;
    logic [3:0] latCount;
    logic       accWe;
    logic       fetchWins;
    logic       memWins;

    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        fetchWins = 1'b0;
        memWins   = 1'b0;
        if (mem_req && if_req && (streak == BURST_MAX)) begin
            fetchWins = 1'b1;
        end else if (mem_req) begin
            memWins = 1'b1;
        end else if (if_req) begin
            fetchWins = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= GRANT_NONE;
            streak    <= 4'd0;
            latCount  <= 4'd0;
            accWe     <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 16'd0;
            ram_wdata <= 16'd0;
            if_rdata  <= 16'd0;
            mem_rdata <= 16'd0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetchWins) begin
                        grant    <= GRANT_FETCH;
                        accWe    <= 1'b0;
                        ram_addr <= if_addr;
                        ram_en   <= 1'b1;
                        streak   <= 4'd0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end else if (memWins) begin
                        grant     <= GRANT_MEM;
                        accWe     <= mem_we;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                        ram_en    <= 1'b1;
                        ram_we    <= mem_we;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                        if (!if_req) begin
                            streak <= 4'd0;
                        end else if (streak < BURST_MAX) begin
                            streak <= streak + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    latCount <= LAT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (latCount == 4'd0) begin
                        if (!accWe) begin
                            if (grant == GRANT_FETCH) begin
                                if_rdata <= ram_rdata;
                            end else begin
                                mem_rdata <= ram_rdata;
                            end
                        end
                        if_ready  <= (grant == GRANT_FETCH);
                        mem_ready <= (grant == GRANT_MEM);
                        state     <= RESP;
                    end else begin
                        latCount <= latCount - 4'd1;
                    end
                end
                RESP: begin
                    grant <= GRANT_NONE;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
// Main instance uses default latency; two extra instances cover MEM_LATENCY=1 and 5.

module tb_mem_port_arbiter;

    localparam int LAT = 2;

    typedef struct packed {
        logic        isFetch;
        logic [15:0] data;
    } sbEntry_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, mem_req, mem_we;
    logic [15:0] if_addr, mem_addr, mem_wdata;
    logic [15:0] if_rdata, mem_rdata;
    logic        if_ready, if_stall, mem_ready, mem_stall;
    logic        ram_en, ram_we, busy;
    logic [15:0] ram_addr, ram_wdata;
    logic [15:0] ram_rdata;

    logic        x1Req, x5Req;
    logic [15:0] xAddr;
    logic [15:0] xRdata;
    logic [15:0] x1Rdata, x5Rdata, x1IfRdata, x5IfRdata, x1RamAddr, x5RamAddr, x1RamWdata, x5RamWdata;
    logic        x1Ready, x5Ready, x1IfReady, x5IfReady, x1IfStall, x5IfStall, x1Stall, x5Stall;
    logic        x1RamEn, x5RamEn, x1RamWe, x5RamWe, x1Busy, x5Busy;

    int          checks = 0;
    int          errors = 0;
    sbEntry_t    sbQ[$];
    logic [15:0] ramMem[0:255];
    logic [15:0] expMemRdata, expIfRdata;
    logic        rdActive = 1'b0;
    logic [15:0] rdAddr = 16'd0;
    int          rdAge = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_DATA_BURST(3)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .MAX_DATA_BURST(3)) dutLat1 (
        .clock(clock), .reset(reset),
        .if_req(1'b0), .if_addr(16'd0), .if_rdata(x1IfRdata), .if_ready(x1IfReady), .if_stall(x1IfStall),
        .mem_req(x1Req), .mem_we(1'b0), .mem_addr(xAddr), .mem_wdata(16'd0),
        .mem_rdata(x1Rdata), .mem_ready(x1Ready), .mem_stall(x1Stall),
        .ram_en(x1RamEn), .ram_we(x1RamWe), .ram_addr(x1RamAddr), .ram_wdata(x1RamWdata),
        .ram_rdata(xRdata), .busy(x1Busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(5), .MAX_DATA_BURST(3)) dutLat5 (
        .clock(clock), .reset(reset),
        .if_req(1'b0), .if_addr(16'd0), .if_rdata(x5IfRdata), .if_ready(x5IfReady), .if_stall(x5IfStall),
        .mem_req(x5Req), .mem_we(1'b0), .mem_addr(xAddr), .mem_wdata(16'd0),
        .mem_rdata(x5Rdata), .mem_ready(x5Ready), .mem_stall(x5Stall),
        .ram_en(x5RamEn), .ram_we(x5RamWe), .ram_addr(x5RamAddr), .ram_wdata(x5RamWdata),
        .ram_rdata(xRdata), .busy(x5Busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // Fixed-latency RAM: data is only valid in the single cycle LAT cycles after ram_en.
    always @(negedge clock) begin
        if (ram_en) begin
            if (ram_we) begin
                ramMem[ram_addr[7:0]] = ram_wdata;
                rdActive = 1'b0;
            end else begin
                rdActive = 1'b1;
                rdAddr   = ram_addr;
                rdAge    = 0;
            end
        end else if (rdActive) begin
            rdAge++;
        end
        ram_rdata = (rdActive && rdAge == LAT) ? ramMem[rdAddr[7:0]] : 16'hDEAD;
        if (rdActive && rdAge >= LAT) rdActive = 1'b0;
    end

    // Scoreboard: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && (if_ready || mem_ready)) begin
            chkBit("sb_one_ready", if_ready & mem_ready, 1'b0);
            if (sbQ.size() == 0) begin
                chkBit("sb_unexpected_ready", 1'b1, 1'b0);
            end else begin
                sbEntry_t e;
                e = sbQ.pop_front();
                chkBit("sb_port", if_ready, e.isFetch);
                chk("sb_data", if_ready ? if_rdata : mem_rdata, e.data);
            end
        end
    end

    task automatic pushExp(input logic isFetch, input logic we, input logic [15:0] addr);
        sbEntry_t e;
        e.isFetch = isFetch;
        if (isFetch) begin
            expIfRdata = ramMem[addr[7:0]];
            e.data = expIfRdata;
        end else begin
            if (!we) expMemRdata = ramMem[addr[7:0]];
            e.data = expMemRdata;
        end
        sbQ.push_back(e);
    endtask

    // Starts at a negedge in cycle 0 and returns at the negedge of the following IDLE cycle.
    task automatic doAccess(input logic isFetch, input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, input string tag);
        if (isFetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        end
        pushExp(isFetch, isFetch ? 1'b0 : we, addr);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clock);
            chkBit({tag, "_ram_en"}, ram_en, k == 1);
            chkBit({tag, "_busy"}, busy, 1'b1);
            chkBit({tag, "_if_ready"}, if_ready, isFetch && k == LAT + 2);
            chkBit({tag, "_mem_ready"}, mem_ready, !isFetch && k == LAT + 2);
            if (k == 1) begin
                chk({tag, "_ram_addr"}, ram_addr, addr);
                chkBit({tag, "_ram_we"}, ram_we, we);
                if (we) chk({tag, "_ram_wdata"}, ram_wdata, wdata);
            end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        @(negedge clock);
        chkBit({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] gotAddr[$];
        logic [15:0] expAddr[5];
        int          firstIf;
        int          memBefore;

        for (int i = 0; i < 256; i++) ramMem[i] = 16'(i * 16'h0101) ^ 16'h5A00;
        ramMem[3] = 16'h00A5;
        expMemRdata = 16'd0; expIfRdata = 16'd0;
        reset = 1'b1;
        if_req = 1'b0; if_addr = 16'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 16'd0; mem_wdata = 16'd0;
        x1Req = 1'b0; x5Req = 1'b0; xAddr = 16'd0; xRdata = 16'h00A5;
        repeat (3) @(negedge clock);

        chkBit("rst_ram_en", ram_en, 1'b0);
        chkBit("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 16'd0);
        chk("rst_ram_wdata", ram_wdata, 16'd0);
        chk("rst_if_rdata", if_rdata, 16'd0);
        chk("rst_mem_rdata", mem_rdata, 16'd0);
        chkBit("rst_if_ready", if_ready, 1'b0);
        chkBit("rst_mem_ready", mem_ready, 1'b0);
        chkBit("rst_busy", busy, 1'b0);
        reset = 1'b0;

        doAccess(1'b0, 1'b0, 16'h0003, 16'h0000, "load");
        doAccess(1'b0, 1'b1, 16'h0003, 16'h0001, "store");
        chk("store_rdata_kept", mem_rdata, 16'h00A5);
        doAccess(1'b0, 1'b0, 16'h0003, 16'h0000, "reload");
        doAccess(1'b1, 1'b0, 16'h0007, 16'h0000, "fetch");

        // Simultaneous requests: MEM first, fetch follows once mem_req drops.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0010;
        if_req = 1'b1; if_addr = 16'h0020;
        pushExp(1'b0, 1'b0, 16'h0010);
        pushExp(1'b1, 1'b0, 16'h0020);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            if (k == 1) chk("sim_first_addr", ram_addr, 16'h0010);
            if (k == 6) begin
                chkBit("sim_second_en", ram_en, 1'b1);
                chk("sim_second_addr", ram_addr, 16'h0020);
            end
            chkBit("sim_if_stall", if_stall, k < 9);
            chkBit("sim_mem_ready", mem_ready, k == 4);
            chkBit("sim_if_ready", if_ready, k == 9);
            if (k == 4) mem_req = 1'b0;
        end
        if_req = 1'b0;
        @(negedge clock);

        // Starvation guard with both requests held.
        mem_req = 1'b1; mem_addr = 16'h0040;
        if_req = 1'b1; if_addr = 16'h0050;
        expAddr = '{16'h0040, 16'h0040, 16'h0040, 16'h0050, 16'h0040};
        for (int i = 0; i < 5; i++) pushExp(i == 3, 1'b0, expAddr[i]);
        firstIf = -1;
        memBefore = 0;
        for (int k = 1; k <= 5 * (LAT + 3) - 1; k++) begin
            @(negedge clock);
            if (ram_en) gotAddr.push_back(ram_addr);
            if (mem_ready && firstIf < 0) memBefore++;
            if (if_ready && firstIf < 0) firstIf = k;
            if (k == 5 * (LAT + 3) - 1) begin
                mem_req = 1'b0; if_req = 1'b0;
            end
        end
        chk("starve_grants", 16'(gotAddr.size()), 16'd5);
        for (int i = 0; i < 5 && i < gotAddr.size(); i++) chk("starve_order", gotAddr[i], expAddr[i]);
        chk("starve_first_if", 16'(firstIf), 16'(4 * (LAT + 3) - 1));
        chk("starve_mem_before", 16'(memBefore), 16'd3);
        @(negedge clock);

        // Reset during WAIT aborts the access without a ready pulse.
        mem_req = 1'b1; mem_addr = 16'h0005;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1; mem_req = 1'b0;
        @(negedge clock);
        chkBit("abort_busy", busy, 1'b0);
        chkBit("abort_ram_en", ram_en, 1'b0);
        chkBit("abort_ram_we", ram_we, 1'b0);
        chkBit("abort_mem_ready", mem_ready, 1'b0);
        chk("abort_mem_rdata", mem_rdata, 16'd0);
        expMemRdata = 16'd0; expIfRdata = 16'd0;
        reset = 1'b0;
        @(negedge clock);
        chkBit("abort_no_ready", mem_ready, 1'b0);
        doAccess(1'b0, 1'b0, 16'h0005, 16'h0000, "post_reset");

        // Latency variants.
        x1Req = 1'b1; x5Req = 1'b1; xAddr = 16'h0003;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            chkBit("lat1_ready", x1Ready, k == 3);
            chkBit("lat5_ready", x5Ready, k == 7);
            if (k == 3) begin chk("lat1_rdata", x1Rdata, 16'h00A5); x1Req = 1'b0; end
            if (k == 7) begin chk("lat5_rdata", x5Rdata, 16'h00A5); x5Req = 1'b0; end
        end

        chk("sb_drained", 16'(sbQ.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
